// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-style control FSM: Moore decode of control signals per state,
// with a bounded wait on mem_ready in FETCH, MEMRD and MEMWR that faults to a sticky ERR.
module mc_control_unit #(
   parameter int MEM_HANDSHAKE = 1,
   parameter int WAIT_MAX      = 15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] Op,
   input  logic       mem_ready,
   output logic       PCWr,
   output logic       PCWrCond,
   output logic       IorD,
   output logic       MemRd,
   output logic       MemWr,
   output logic       IRWr,
   output logic       ALUSrcA,
   output logic       RegWr,
   output logic       BrNe,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUSrcB,
   output logic [1:0] RegDst,
   output logic [1:0] MemtoReg,
   output logic [2:0] ALUOp,
   output logic       Err,
   output logic [3:0] State
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_RTEX   = 4'd6,
      S_RTWB   = 4'd7,
      S_BR     = 4'd8,
      S_JMP    = 4'd9,
      S_JAL    = 4'd10,
      S_IEX    = 4'd11,
      S_IWB    = 4'd12,
      S_ERR    = 4'd13
   } state_t;

   localparam int            CW         = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
   localparam logic [CW-1:0] WAIT_MAX_C = CW'(WAIT_MAX);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          rdy;
   logic          in_wait;
   logic          timeout;

   // Without the handshake, memory is assumed single-cycle, so the counter never moves.
   assign rdy     = (MEM_HANDSHAKE != 0) ? mem_ready : 1'b1;
   assign in_wait = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign timeout = (cnt_q == WAIT_MAX_C) && !rdy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      PCWr     = 1'b0;
      PCWrCond = 1'b0;
      IorD     = 1'b0;
      MemRd    = 1'b0;
      MemWr    = 1'b0;
      IRWr     = 1'b0;
      ALUSrcA  = 1'b0;
      RegWr    = 1'b0;
      BrNe     = 1'b0;
      PCSrc    = 2'b00;
      ALUSrcB  = 2'b00;
      RegDst   = 2'b00;
      MemtoReg = 2'b00;
      ALUOp    = 3'b000;
      case (state_q)
         S_FETCH: begin
            MemRd   = 1'b1;
            ALUSrcB = 2'b01;
            IRWr    = rdy;
            PCWr    = rdy;
            if (rdy)          state_d = S_DECODE;
            else if (timeout) state_d = S_ERR;
         end
         S_DECODE: begin
            ALUSrcB = 2'b11;
            case (Op)
               6'b100011, 6'b101011: state_d = S_MEMADR;
               6'b000000:            state_d = S_RTEX;
               6'b000100, 6'b000101: state_d = S_BR;
               6'b000010:            state_d = S_JMP;
               6'b000011:            state_d = S_JAL;
               6'b001000, 6'b001100, 6'b001101,
               6'b001110, 6'b001111: state_d = S_IEX;
               default:              state_d = S_ERR;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            state_d = (Op == 6'b100011) ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            MemRd = 1'b1;
            IorD  = 1'b1;
            if (rdy)          state_d = S_MEMWB;
            else if (timeout) state_d = S_ERR;
         end
         S_MEMWB: begin
            RegWr    = 1'b1;
            MemtoReg = 2'b01;
            state_d  = S_FETCH;
         end
         S_MEMWR: begin
            MemWr = 1'b1;
            IorD  = 1'b1;
            if (rdy)          state_d = S_FETCH;
            else if (timeout) state_d = S_ERR;
         end
         S_RTEX: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b010;
            state_d = S_RTWB;
         end
         S_RTWB: begin
            RegWr   = 1'b1;
            RegDst  = 2'b01;
            state_d = S_FETCH;
         end
         S_BR: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 3'b001;
            PCWrCond = 1'b1;
            PCSrc    = 2'b01;
            BrNe     = Op[0];
            state_d  = S_FETCH;
         end
         S_JMP: begin
            PCWr    = 1'b1;
            PCSrc   = 2'b10;
            state_d = S_FETCH;
         end
         S_JAL: begin
            PCWr     = 1'b1;
            PCSrc    = 2'b10;
            RegWr    = 1'b1;
            RegDst   = 2'b10;
            MemtoReg = 2'b10;
            state_d  = S_FETCH;
         end
         S_IEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            case (Op)
               6'b001100: ALUOp = 3'b011;
               6'b001101: ALUOp = 3'b100;
               6'b001110: ALUOp = 3'b101;
               6'b001111: ALUOp = 3'b110;
               default:   ALUOp = 3'b000;
            endcase
            state_d = S_IWB;
         end
         S_IWB: begin
            RegWr   = 1'b1;
            state_d = S_FETCH;
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_ERR;
      endcase
   end

   // Counter restarts on any state change and saturates at WAIT_MAX.
   always_comb begin
      cnt_d = cnt_q;
      if (state_d != state_q)
         cnt_d = '0;
      else if (in_wait && !rdy && (cnt_q != WAIT_MAX_C))
         cnt_d = cnt_q + 1'b1;
   end

   assign Err   = (state_q == S_ERR);
   assign State = state_q;

endmodule
